// File: rtl/mux16_scan_ctrl.sv
// Scan sequencer for a 16:1 mux built from two 4:1 stages: steps the selects through
// channels 0..15, samples y after a programmable settle time and publishes a snapshot.
module mux16_scan_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        cont,
    input  logic        y,
    output logic        s0,
    output logic        s1,
    output logic        s2,
    output logic        s3,
    output logic        busy,
    output logic        done,
    output logic [15:0] data
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_SAMPLE = 2'd3;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);
    // With no settle time each channel goes straight to its sample cycle.
    localparam logic [1:0] ST_FIRST  = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    logic [1:0]  r_state;
    logic [3:0]  r_ch;
    logic [3:0]  r_cnt;
    logic [3:0]  r_sel;
    logic [15:0] r_shadow;
    logic [15:0] r_data;
    logic        r_busy;
    logic        r_done;
    logic [15:0] w_shadow_upd;
    logic [3:0]  w_ch_next;

    // Select pattern {s0,s1,s2,s3} for a channel number.
    function automatic logic [3:0] f_sel(input logic [3:0] ch);
        f_sel = {ch[1], ch[0], ch[3], ch[2]};
    endfunction

    // Shadow word with the current channel's bit replaced by y.
    always_comb begin
        w_shadow_upd       = r_shadow;
        w_shadow_upd[r_ch] = y;
        w_ch_next          = r_ch + 4'd1;
    end

    // Scan state machine, channel/settle counters, shadow and snapshot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ch     <= 4'd0;
            r_cnt    <= 4'd0;
            r_sel    <= 4'd0;
            r_shadow <= 16'h0000;
            r_data   <= 16'h0000;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_state  <= ST_ARM;
                        r_busy   <= 1'b1;
                        r_ch     <= 4'd0;
                        r_sel    <= 4'd0;
                        r_shadow <= 16'h0000;
                    end
                end
                default: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_ch    <= 4'd0;
                        r_sel   <= 4'd0;
                    end else begin
                        case (r_state)
                            ST_ARM: begin
                                r_state <= ST_FIRST;
                                r_cnt   <= SETTLE_LD;
                            end
                            ST_SETTLE: begin
                                if (r_cnt == 4'd1) begin
                                    r_state <= ST_SAMPLE;
                                end else begin
                                    r_cnt <= r_cnt - 4'd1;
                                end
                            end
                            ST_SAMPLE: begin
                                if (r_ch == 4'd15) begin
                                    r_data <= w_shadow_upd;
                                    r_done <= 1'b1;
                                    r_ch   <= 4'd0;
                                    r_sel  <= 4'd0;
                                    // Continuous mode re-enters channel 0 with no idle gap.
                                    if (cont) begin
                                        r_shadow <= 16'h0000;
                                        r_state  <= ST_FIRST;
                                        r_cnt    <= SETTLE_LD;
                                    end else begin
                                        r_shadow <= w_shadow_upd;
                                        r_state  <= ST_IDLE;
                                        r_busy   <= 1'b0;
                                    end
                                end else begin
                                    r_shadow <= w_shadow_upd;
                                    r_ch     <= w_ch_next;
                                    r_sel    <= f_sel(w_ch_next);
                                    r_state  <= ST_FIRST;
                                    r_cnt    <= SETTLE_LD;
                                end
                            end
                            default: begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign s0   = r_sel[3];
    assign s1   = r_sel[2];
    assign s2   = r_sel[1];
    assign s3   = r_sel[0];
    assign busy = r_busy;
    assign done = r_done;
    assign data = r_data;

endmodule
